// File: rtl/axis_frame_tx_if.sv
// Bundle of the FIFO write port, frame-control handshake and AXI-Stream master
// signals used by axis_frame_tx.
interface axis_frame_tx_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic [CW-1:0]         wr_count;
    logic                  start;
    logic [CW-1:0]         frame_len;
    logic                  busy;
    logic                  done;
    logic                  m_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    // master: the frame transmitter itself
    modport master (
        input  wr_en, wr_data, start, frame_len, m_axis_tready,
        output wr_full, wr_count, busy, done, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    // slave: the writer / frame requester / stream consumer
    modport slave (
        output wr_en, wr_data, start, frame_len, m_axis_tready,
        input  wr_full, wr_count, busy, done, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/axis_frame_tx.sv
// Word FIFO feeding an AXI-Stream master that emits frames of a requested length,
// with TLAST on the final beat and a one-cycle DONE pulse afterwards.
module axis_frame_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input logic             aclk,
    input logic             areset,
    axis_frame_tx_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         len;
    logic [CW-1:0]         beat;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  start_ok;
    logic [DATA_WIDTH-1:0] head_nxt;

    assign bus.wr_count = count;
    assign bus.wr_full  = full;

    // Next-cycle FIFO view; the registered TDATA tracks the head after this edge,
    // bypassing the write data when the write lands on an otherwise empty FIFO.
    always_comb begin
        push       = bus.wr_en && !full;
        pop        = (state == SEND) && bus.m_axis_tready;
        rd_ptr_nxt = rd_ptr + AW'(pop);
        count_nxt  = count + CW'(push) - CW'(pop);
        head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? bus.wr_data : mem[rd_ptr_nxt];
        start_ok   = (state == IDLE) && bus.start
                     && (bus.frame_len != '0) && (bus.frame_len <= CW'(DEPTH))
                     && (count >= bus.frame_len);
    end

    // Storage array carries no reset; pointers alone define its contents.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            full              <= 1'b0;
            len               <= '0;
            beat              <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.m_axis_tvalid <= 1'b0;
            bus.m_axis_tlast  <= 1'b0;
            bus.m_axis_tdata  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr           <= rd_ptr_nxt;
            count            <= count_nxt;
            full             <= (count_nxt == CW'(DEPTH));
            bus.m_axis_tdata <= head_nxt;
            bus.done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state             <= SEND;
                        len               <= bus.frame_len;
                        beat              <= '0;
                        bus.busy          <= 1'b1;
                        bus.m_axis_tvalid <= 1'b1;
                        bus.m_axis_tlast  <= (bus.frame_len == CW'(1));
                    end
                end
                SEND: begin
                    if (pop) begin
                        if (bus.m_axis_tlast) begin
                            state             <= IDLE;
                            bus.busy          <= 1'b0;
                            bus.m_axis_tvalid <= 1'b0;
                            bus.m_axis_tlast  <= 1'b0;
                            bus.done          <= 1'b1;
                        end else begin
                            beat             <= beat + CW'(1);
                            bus.m_axis_tlast <= ((beat + CW'(1)) == (len - CW'(1)));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
